// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer.
// ROB_SIZE_BITS is the single sizing constant; everything else derives from it.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_BITS = 4;
  localparam int ROB_DEPTH     = 1 << ROB_SIZE_BITS;
  localparam int DISP_W        = 2;
  localparam int COMP_W        = 3;
  localparam int RET_W         = 2;
  localparam int PREG_W        = 6;
  localparam int PC_W          = 32;

  typedef logic [ROB_SIZE_BITS-1:0] rob_idx_t;
  typedef logic [ROB_SIZE_BITS:0]   rob_cnt_t;

  typedef struct packed {
    logic RegWrite;
  } controlStruct;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    controlStruct      control;
  } dispatchStruct;

  typedef struct packed {
    logic     valid;
    rob_idx_t robNum;
  } completeStruct;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [PC_W-1:0]   pc;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    logic              RegWrite;
  } robEntry;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    logic              RegWrite;
    logic [PC_W-1:0]   pc;
  } retireStruct;

endpackage

// File: rtl/reorder_buffer.sv
// 16-entry in-order reorder buffer: allocates up to two entries per cycle at
// the tail, marks entries done from three completion ports, and retires up to
// two consecutive done entries per cycle from the head.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic          [DISP_W-1:0]              disp_valid,
  input  dispatchStruct [DISP_W-1:0]              disp_inst,
  output logic                                    disp_ready,
  output logic          [DISP_W-1:0][ROB_SIZE_BITS-1:0] disp_robNum,
  input  completeStruct [COMP_W-1:0]              comp,
  output logic          [RET_W-1:0]               ret_valid,
  output logic          [RET_W-1:0][PREG_W-1:0]   ret_rd,
  output logic          [RET_W-1:0][PREG_W-1:0]   ret_rd_old,
  output logic          [RET_W-1:0]               ret_RegWrite,
  output logic          [RET_W-1:0][PC_W-1:0]     ret_pc,
  output logic          [ROB_SIZE_BITS:0]         rob_count,
  output logic                                    rob_empty
);

  // Control state (reset) and entry payload (not reset; qualified by valid).
  rob_idx_t                head;
  rob_idx_t                tail;
  rob_cnt_t                count;
  logic [ROB_DEPTH-1:0]    ent_valid;
  logic [ROB_DEPTH-1:0]    ent_done;
  logic [PC_W-1:0]         ent_pc       [ROB_DEPTH];
  logic [PREG_W-1:0]       ent_rd       [ROB_DEPTH];
  logic [PREG_W-1:0]       ent_rd_old   [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]    ent_regwrite;

  logic                    disp_fire;
  logic [DISP_W-1:0]       disp_slot;
  rob_cnt_t                n_disp;
  rob_cnt_t                n_ret;
  rob_idx_t                ret_idx  [RET_W];
  robEntry                 ret_ent  [RET_W];
  retireStruct             ret_slot [RET_W];
  logic                    comp_bad;
  logic                    comp_dup;

  // Registered count only: a same-cycle retire does not open up space.
  assign disp_ready = (count <= rob_cnt_t'(ROB_DEPTH - 2));
  // Slot 0 must be valid for any allocation, which also drops the 2'b10 pattern.
  assign disp_fire  = disp_ready && disp_valid[0];
  assign disp_slot  = disp_fire ? disp_valid : '0;
  assign n_disp     = rob_cnt_t'($countones(disp_slot));
  assign n_ret      = rob_cnt_t'($countones(ret_valid));
  assign rob_count  = count;
  assign rob_empty  = (count == '0);

  // Allocation indices: consecutive entries starting at the tail.
  always_comb begin
    for (int d = 0; d < DISP_W; d++) begin
      disp_robNum[d] = tail + rob_idx_t'(d);
    end
  end

  // Retire selection: a slot retires only if every older slot also retires.
  always_comb begin
    logic chain;
    chain = 1'b1;
    for (int i = 0; i < RET_W; i++) begin
      ret_idx[i] = head + rob_idx_t'(i);
      ret_ent[i] = '{valid:    ent_valid[ret_idx[i]],
                     done:     ent_done[ret_idx[i]],
                     pc:       ent_pc[ret_idx[i]],
                     rd:       ent_rd[ret_idx[i]],
                     rd_old:   ent_rd_old[ret_idx[i]],
                     RegWrite: ent_regwrite[ret_idx[i]]};
      chain = chain & ret_ent[i].valid & ret_ent[i].done;
      ret_slot[i] = '0;
      ret_slot[i].valid = chain;
      if (chain) begin
        ret_slot[i].rd       = ret_ent[i].rd;
        ret_slot[i].rd_old   = ret_ent[i].rd_old;
        ret_slot[i].RegWrite = ret_ent[i].RegWrite;
        ret_slot[i].pc       = ret_ent[i].pc;
      end
    end
  end

  // Unpack the retire slots onto the flat output ports.
  always_comb begin
    for (int i = 0; i < RET_W; i++) begin
      ret_valid[i]    = ret_slot[i].valid;
      ret_rd[i]       = ret_slot[i].rd;
      ret_rd_old[i]   = ret_slot[i].rd_old;
      ret_RegWrite[i] = ret_slot[i].RegWrite;
      ret_pc[i]       = ret_slot[i].pc;
    end
  end

  // Pointer, count and valid/done bookkeeping; later loops take priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      for (int c = 0; c < COMP_W; c++) begin
        if (comp[c].valid && ent_valid[comp[c].robNum]) begin
          ent_done[comp[c].robNum] <= 1'b1;
        end
      end
      for (int r = 0; r < RET_W; r++) begin
        if (ret_valid[r]) begin
          ent_valid[ret_idx[r]] <= 1'b0;
          ent_done[ret_idx[r]]  <= 1'b0;
        end
      end
      for (int d = 0; d < DISP_W; d++) begin
        if (disp_slot[d]) begin
          ent_valid[disp_robNum[d]] <= 1'b1;
          ent_done[disp_robNum[d]]  <= 1'b0;
        end
      end
      head  <= head + rob_idx_t'(n_ret);
      tail  <= tail + rob_idx_t'(n_disp);
      count <= count + n_disp - n_ret;
    end
  end

  // Payload capture for newly allocated entries.
  always_ff @(posedge clk) begin
    for (int d = 0; d < DISP_W; d++) begin
      if (disp_slot[d]) begin
        ent_pc[disp_robNum[d]]       <= disp_inst[d].pc;
        ent_rd[disp_robNum[d]]       <= disp_inst[d].rd;
        ent_rd_old[disp_robNum[d]]   <= disp_inst[d].rd_old;
        ent_regwrite[disp_robNum[d]] <= disp_inst[d].control.RegWrite;
      end
    end
  end

  // Illegal completion detection: unallocated target or two ports on one entry.
  always_comb begin
    comp_bad = 1'b0;
    comp_dup = 1'b0;
    for (int i = 0; i < COMP_W; i++) begin
      if (comp[i].valid && !ent_valid[comp[i].robNum]) comp_bad = 1'b1;
      for (int j = i + 1; j < COMP_W; j++) begin
        if (comp[i].valid && comp[j].valid && comp[i].robNum == comp[j].robNum) comp_dup = 1'b1;
      end
    end
  end

  a_disp_pattern: assert property (@(posedge clk) disable iff (!reset_n)
    !(!disp_valid[0] && disp_valid[1]));
  a_comp_valid:   assert property (@(posedge clk) disable iff (!reset_n) !comp_bad);
  a_comp_unique:  assert property (@(posedge clk) disable iff (!reset_n) !comp_dup);

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a random
// run, all compared against a queue-based program-order model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  typedef dispatchStruct [1:0] disp_vec_t;
  typedef completeStruct [2:0] comp_vec_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [1:0]      disp_valid;
  disp_vec_t       disp_inst;
  logic            disp_ready;
  logic [1:0][3:0] disp_robNum;
  comp_vec_t       comp;
  logic [1:0]      ret_valid;
  logic [1:0][5:0] ret_rd;
  logic [1:0][5:0] ret_rd_old;
  logic [1:0]      ret_RegWrite;
  logic [1:0][31:0] ret_pc;
  logic [4:0]      rob_count;
  logic            rob_empty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  rd;
    logic [5:0]  rd_old;
    logic        rw;
    bit          done;
  } ment_t;

  ment_t mq[$];
  int    m_head = 0;

  reorder_buffer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .disp_valid   (disp_valid),
    .disp_inst    (disp_inst),
    .disp_ready   (disp_ready),
    .disp_robNum  (disp_robNum),
    .comp         (comp),
    .ret_valid    (ret_valid),
    .ret_rd       (ret_rd),
    .ret_rd_old   (ret_rd_old),
    .ret_RegWrite (ret_RegWrite),
    .ret_pc       (ret_pc),
    .rob_count    (rob_count),
    .rob_empty    (rob_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_ret_valid();
    logic [1:0] v;
    v = 2'b00;
    if (mq.size() > 0 && mq[0].done) begin
      v[0] = 1'b1;
      if (mq.size() > 1 && mq[1].done) v[1] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic exp_ready();
    return (mq.size() <= 14);
  endfunction

  function automatic logic [3:0] exp_rob(int k);
    return 4'((m_head + mq.size() + k) % 16);
  endfunction

  function automatic disp_vec_t mkd(logic [31:0] pc0, logic [31:0] pc1);
    disp_vec_t d;
    d = '0;
    d[0].pc = pc0;
    d[0].rd = 6'($urandom);
    d[0].rd_old = 6'($urandom);
    d[0].control.RegWrite = 1'($urandom);
    d[1].pc = pc1;
    d[1].rd = 6'($urandom);
    d[1].rd_old = 6'($urandom);
    d[1].control.RegWrite = 1'($urandom);
    return d;
  endfunction

  function automatic comp_vec_t mkc(int n, int a, int b, int c);
    comp_vec_t cv;
    cv = '0;
    if (n > 0) begin cv[0].valid = 1'b1; cv[0].robNum = 4'(a); end
    if (n > 1) begin cv[1].valid = 1'b1; cv[1].robNum = 4'(b); end
    if (n > 2) begin cv[2].valid = 1'b1; cv[2].robNum = 4'(c); end
    return cv;
  endfunction

  // One clock: drive at negedge, advance the model at posedge, idle at next negedge.
  task automatic cycle(input logic [1:0] dv, input disp_vec_t di, input comp_vec_t cp);
    logic [1:0] rv;
    bit acc;
    int pos;
    disp_valid = dv;
    disp_inst  = di;
    comp       = cp;
    rv  = exp_ret_valid();
    acc = exp_ready() && (dv == 2'b01 || dv == 2'b11);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (cp[c].valid) begin
        pos = (int'(cp[c].robNum) - m_head + 16) % 16;
        if (pos < mq.size()) mq[pos].done = 1'b1;
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (rv[r]) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % 16;
      end
    end
    if (acc) begin
      for (int d = 0; d < 2; d++) begin
        if (dv[d]) mq.push_back('{di[d].pc, di[d].rd, di[d].rd_old, di[d].control.RegWrite, 1'b0});
      end
    end
    @(negedge clk);
    disp_valid = 2'b00;
    comp       = '0;
  endtask

  // Complete everything outstanding and let it retire (bounded).
  task automatic drain();
    comp_vec_t cp;
    int n;
    int guard;
    guard = 0;
    while (mq.size() > 0 && guard < 64) begin
      cp = '0;
      n = 0;
      for (int p = 0; p < mq.size(); p++) begin
        if (!mq[p].done && n < 3) begin
          cp[n].valid  = 1'b1;
          cp[n].robNum = 4'((m_head + p) % 16);
          n++;
        end
      end
      cycle(2'b00, '0, cp);
      guard++;
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    mq.delete();
    m_head = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    disp_valid = 2'b00;
    disp_inst  = '0;
    comp       = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ret_valid !== 2'b00) begin errors++; $display("FAIL reset_ret_valid: got %b want 00", ret_valid); end
    checks++; if (rob_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", rob_count); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", rob_empty); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", disp_ready); end
    checks++; if (disp_robNum[0] !== 4'd0 || disp_robNum[1] !== 4'd1) begin
      errors++; $display("FAIL reset_robnum: got %0d,%0d want 0,1", disp_robNum[0], disp_robNum[1]); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    disp_vec_t di;
    di = mkd(32'h100, 32'h104);
    di[0].rd_old = 6'd5;
    di[1].rd_old = 6'd6;
    di[0].rd = 6'd20;
    di[1].rd = 6'd21;
    di[0].control.RegWrite = 1'b1;
    di[1].control.RegWrite = 1'b0;
    checks++; if (disp_robNum[0] !== 4'd0 || disp_robNum[1] !== 4'd1) begin
      errors++; $display("FAIL basic_robnum: got %0d,%0d want 0,1", disp_robNum[0], disp_robNum[1]); end
    cycle(2'b11, di, '0);
    checks++; if (rob_count !== 5'd2) begin errors++; $display("FAIL basic_count2: got %0d want 2", rob_count); end
    cycle(2'b00, '0, mkc(1, 1, 0, 0));
    checks++; if (ret_valid !== 2'b00) begin errors++; $display("FAIL basic_young_done: got %b want 00", ret_valid); end
    cycle(2'b00, '0, mkc(1, 0, 0, 0));
    checks++; if (ret_valid !== 2'b11) begin errors++; $display("FAIL basic_ret_valid: got %b want 11", ret_valid); end
    checks++; if (ret_rd_old[0] !== 6'd5 || ret_rd_old[1] !== 6'd6) begin
      errors++; $display("FAIL basic_rd_old: got %0d,%0d want 5,6", ret_rd_old[0], ret_rd_old[1]); end
    checks++; if (ret_pc[0] !== 32'h100 || ret_pc[1] !== 32'h104) begin
      errors++; $display("FAIL basic_pc: got %h,%h want 100,104", ret_pc[0], ret_pc[1]); end
    checks++; if (ret_rd[0] !== 6'd20 || ret_rd[1] !== 6'd21 || ret_RegWrite !== 2'b01) begin
      errors++; $display("FAIL basic_rd_rw: got %0d,%0d rw=%b want 20,21 rw=01", ret_rd[0], ret_rd[1], ret_RegWrite); end
    cycle(2'b00, '0, '0);
    checks++; if (rob_count !== 5'd0 || rob_empty !== 1'b1) begin
      errors++; $display("FAIL basic_drained: got count=%0d empty=%b want 0,1", rob_count, rob_empty); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 8; k++) begin
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL full_ready_fill: got %b want 1 at k=%0d", disp_ready, k); end
      cycle(2'b11, mkd(32'h2000 + 8 * k, 32'h2004 + 8 * k), '0);
    end
    checks++; if (rob_count !== 5'd16 || disp_ready !== 1'b0) begin
      errors++; $display("FAIL full_16: got count=%0d ready=%b want 16,0", rob_count, disp_ready); end
    cycle(2'b11, mkd(32'hdead, 32'hbeef), '0);
    checks++; if (rob_count !== 5'd16) begin errors++; $display("FAIL full_blocked: got %0d want 16", rob_count); end
    cycle(2'b00, '0, mkc(1, m_head, 0, 0));
    checks++; if (ret_valid !== 2'b01) begin errors++; $display("FAIL full_head_done: got %b want 01", ret_valid); end
    cycle(2'b11, mkd(32'hdead, 32'hbeef), mkc(1, (m_head + 1) % 16, 0, 0));
    checks++; if (rob_count !== 5'd15 || disp_ready !== 1'b0) begin
      errors++; $display("FAIL full_15: got count=%0d ready=%b want 15,0", rob_count, disp_ready); end
    cycle(2'b01, mkd(32'hdead, 32'hbeef), '0);
    checks++; if (rob_count !== 5'd14 || disp_ready !== 1'b1) begin
      errors++; $display("FAIL full_15_blocked: got count=%0d ready=%b want 14,1", rob_count, disp_ready); end
    cycle(2'b00, '0, mkc(1, m_head, 0, 0));
    cycle(2'b01, mkd(32'h3000, 32'h3004), '0);
    checks++; if (rob_count !== 5'd14 || 5'(mq.size()) !== 5'd14) begin
      errors++; $display("FAIL full_disp_and_ret: got %0d want 14", rob_count); end
    checks++; if (mq[13].pc !== 32'h3000) begin errors++; $display("FAIL full_model_tail: got %h want 3000", mq[13].pc); end
    drain();
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL full_drain: got empty=%b want 1", rob_empty); end
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int k = 0; k < 7; k++) cycle(2'b11, mkd(32'h400 + 8 * k, 32'h404 + 8 * k), '0);
    drain();
    checks++; if (disp_robNum[0] !== 4'd14 || disp_robNum[1] !== 4'd15 || rob_empty !== 1'b1) begin
      errors++; $display("FAIL wrap_at14: got %0d,%0d empty=%b want 14,15,1", disp_robNum[0], disp_robNum[1], rob_empty); end
    cycle(2'b11, mkd(32'ha0, 32'ha4), '0);
    checks++; if (disp_robNum[0] !== 4'd0 || disp_robNum[1] !== 4'd1) begin
      errors++; $display("FAIL wrap_robnum: got %0d,%0d want 0,1", disp_robNum[0], disp_robNum[1]); end
    cycle(2'b11, mkd(32'hb0, 32'hb4), '0);
    cycle(2'b00, '0, mkc(3, 14, 15, 0));
    checks++; if (ret_valid !== 2'b11 || ret_pc[0] !== 32'ha0 || ret_pc[1] !== 32'ha4) begin
      errors++; $display("FAIL wrap_ret1: got %b %h,%h want 11 a0,a4", ret_valid, ret_pc[0], ret_pc[1]); end
    cycle(2'b00, '0, mkc(1, 1, 0, 0));
    checks++; if (ret_valid !== 2'b11 || ret_pc[0] !== 32'hb0 || ret_pc[1] !== 32'hb4) begin
      errors++; $display("FAIL wrap_ret2: got %b %h,%h want 11 b0,b4", ret_valid, ret_pc[0], ret_pc[1]); end
    cycle(2'b00, '0, '0);
    checks++; if (rob_count !== 5'd0 || disp_robNum[0] !== 4'd2) begin
      errors++; $display("FAIL wrap_end: got count=%0d tail=%0d want 0,2", rob_count, disp_robNum[0]); end
  endtask

  task automatic test_random();
    logic [1:0] dv;
    logic [1:0] rv;
    comp_vec_t cp;
    int cand[$];
    int idx;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rv = exp_ret_valid();
      checks++; if (disp_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready: cyc %0d got %b want %b", cyc, disp_ready, exp_ready()); end
      checks++; if (disp_robNum[0] !== exp_rob(0) || disp_robNum[1] !== exp_rob(1)) begin
        errors++; $display("FAIL rnd_robnum: cyc %0d got %0d,%0d want %0d,%0d", cyc, disp_robNum[0], disp_robNum[1], exp_rob(0), exp_rob(1)); end
      checks++; if (rob_count !== 5'(mq.size()) || rob_empty !== (mq.size() == 0)) begin
        errors++; $display("FAIL rnd_count: cyc %0d got %0d/%b want %0d", cyc, rob_count, rob_empty, mq.size()); end
      checks++; if (ret_valid !== rv) begin errors++; $display("FAIL rnd_ret_valid: cyc %0d got %b want %b", cyc, ret_valid, rv); end
      for (int s = 0; s < 2; s++) begin
        checks++;
        if (ret_pc[s] !== (rv[s] ? mq[s].pc : 32'h0) || ret_rd[s] !== (rv[s] ? mq[s].rd : 6'h0) ||
            ret_rd_old[s] !== (rv[s] ? mq[s].rd_old : 6'h0) || ret_RegWrite[s] !== (rv[s] ? mq[s].rw : 1'b0)) begin
          errors++; $display("FAIL rnd_ret_fields: cyc %0d slot %0d got pc=%h rd=%0d old=%0d rw=%b", cyc, s, ret_pc[s], ret_rd[s], ret_rd_old[s], ret_RegWrite[s]);
        end
      end
      case ($urandom_range(0, 3))
        0:       dv = 2'b00;
        1:       dv = 2'b01;
        default: dv = 2'b11;
      endcase
      cand.delete();
      for (int p = 0; p < mq.size(); p++) if (!mq[p].done) cand.push_back((m_head + p) % 16);
      cp = '0;
      for (int c = 0; c < 3; c++) begin
        if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
          idx = $urandom_range(0, cand.size() - 1);
          cp[c].valid  = 1'b1;
          cp[c].robNum = 4'(cand[idx]);
          cand.delete(idx);
        end
      end
      cycle(dv, mkd($urandom, $urandom), cp);
    end
    drain();
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL rnd_drain: got empty=%b want 1", rob_empty); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    for (int k = 0; k < 4; k++) cycle(2'b11, mkd(32'h500 + 8 * k, 32'h504 + 8 * k), '0);
    cycle(2'b01, mkd(32'h540, 32'h0), '0);
    cycle(2'b00, '0, mkc(1, m_head, 0, 0));
    checks++; if (rob_count !== 5'd9 || ret_valid !== 2'b01) begin
      errors++; $display("FAIL mid_pre: got count=%0d ret=%b want 9,01", rob_count, ret_valid); end
    #2 reset_n = 1'b0;
    mq.delete();
    m_head = 0;
    #1;
    checks++; if (ret_valid !== 2'b00 || rob_count !== 5'd0 || rob_empty !== 1'b1 || disp_ready !== 1'b1) begin
      errors++; $display("FAIL mid_async: got ret=%b count=%0d empty=%b ready=%b", ret_valid, rob_count, rob_empty, disp_ready); end
    checks++; if (disp_robNum[0] !== 4'd0 || disp_robNum[1] !== 4'd1) begin
      errors++; $display("FAIL mid_robnum: got %0d,%0d want 0,1", disp_robNum[0], disp_robNum[1]); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cycle(2'b01, mkd(32'h600, 32'h0), '0);
    checks++; if (rob_count !== 5'd1 || disp_robNum[0] !== 4'd1) begin
      errors++; $display("FAIL mid_after: got count=%0d tail=%0d want 1,1", rob_count, disp_robNum[0]); end
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
